// File: rtl/alu_seq.sv
// alu_seq: sequences a 4*NIBBLES-bit operation through an external 4-bit ALU
// slice, one nibble per cycle, rippling the slice carry through a register.
// Ports: clk, rst_n (sync, active-low), start, op_s/op_m/op_cn, a, b (request);
//        alu_s/alu_m/alu_a/alu_b/alu_cn -> slice, alu_f/alu_cn4 <- slice;
//        result, cout, zero, busy, done (status/result).
// Optional: define ALU_SEQ_ZERO_EN to enable the result-equals-zero flag.
`timescale 1ns/1ps
module alu_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [3:0]           op_s,
    input  logic                 op_m,
    input  logic                 op_cn,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic [3:0]           alu_s,
    output logic                 alu_m,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic                 alu_cn,
    input  logic [3:0]           alu_f,
    input  logic                 alu_cn4,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 busy,
    output logic                 done,
    output logic                 zero
);

    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q;
    logic          carry_q;
    logic [3:0]    s_q;
    logic          m_q;
    logic          cn_q;
    logic [W-1:0]  a_q, b_q;
    logic [W-1:0]  result_q;
    logic [W-1:0]  res_next;
    logic          cout_q;
    logic          last;
    logic          accept;

    assign last   = (k_q == KW'(NIBBLES - 1));
    assign accept = start && (state_q != RUN);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: slice drives are quiet outside RUN
    always_comb begin
        busy   = (state_q == RUN);
        done   = (state_q == DONE);
        alu_s  = 4'd0;
        alu_m  = 1'b0;
        alu_a  = 4'd0;
        alu_b  = 4'd0;
        alu_cn = 1'b0;
        if (state_q == RUN) begin
            alu_s  = s_q;
            alu_m  = m_q;
            alu_a  = a_q[4*k_q +: 4];
            alu_b  = b_q[4*k_q +: 4];
            alu_cn = (k_q == '0) ? cn_q : carry_q;
        end
    end

    // Result with the current slice merged in
    always_comb begin
        res_next = result_q;
        res_next[4*k_q +: 4] = alu_f;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_q      <= '0;
            carry_q  <= 1'b0;
            s_q      <= 4'd0;
            m_q      <= 1'b0;
            cn_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else if (accept) begin
            k_q  <= '0;
            s_q  <= op_s;
            m_q  <= op_m;
            cn_q <= op_cn;
            a_q  <= a;
            b_q  <= b;
        end else if (state_q == RUN) begin
            result_q <= res_next;
            carry_q  <= alu_cn4;
            // k holds at the last slice so it never wraps
            if (last) cout_q <= alu_cn4;
            else      k_q    <= k_q + KW'(1);
        end
    end

`ifdef ALU_SEQ_ZERO_EN
    logic zero_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            zero_q <= 1'b0;
        else if (state_q == RUN && last && !accept)
            zero_q <= (res_next == '0);
    end

    assign zero = zero_q;
`else
    assign zero = 1'b0;
`endif

    assign result = result_q;
    assign cout   = cout_q;

endmodule
